// File: rtl/mux2_rr_pkg.sv
// ----------------------------------------------------------------------------
// mux2_rr_pkg
// Shared definitions for the two-channel round-robin arbiter:
//   DW_DEF   - default data width of every data port
//   ostate_t - output stage state (O_EMPTY / O_FULL)
//   SEL_A/B  - grant select encoding, same polarity as the multiplexor select
//              and as the priority register (1 = channel A)
// ----------------------------------------------------------------------------
package mux2_rr_pkg;

   localparam int DW_DEF = 2;

   typedef enum logic {
      O_EMPTY = 1'b0,
      O_FULL  = 1'b1
   } ostate_t;

   localparam logic SEL_A = 1'b1;
   localparam logic SEL_B = 1'b0;

endpackage : mux2_rr_pkg

// File: rtl/mux2_rr_arbiter_mux.sv
// ----------------------------------------------------------------------------
// mux2_rr_arbiter_mux
// Two-input data multiplexor used on the arbiter output path.
// Ports:
//   input_x  in  1   select (SEL_A picks input_a, SEL_B picks input_b)
//   input_a  in  DW  candidate word from channel A
//   input_b  in  DW  candidate word from channel B
//   output_y out DW  selected word
// ----------------------------------------------------------------------------
module mux2_rr_arbiter_mux
   import mux2_rr_pkg::*;
#(
   parameter int DW = DW_DEF
) (
   input  logic          input_x,
   input  logic [DW-1:0] input_a,
   input  logic [DW-1:0] input_b,
   output logic [DW-1:0] output_y
);

   assign output_y = (input_x == SEL_A) ? input_a : input_b;

endmodule : mux2_rr_arbiter_mux

// File: rtl/mux2_rr_arbiter.sv
// ----------------------------------------------------------------------------
// mux2_rr_arbiter
// Merges two valid/ready channels into one output stream. Each channel has a
// one-entry skid buffer; a round-robin priority register decides which full
// buffer feeds the registered output stage. All outputs come from flops.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   a_valid/a_data      channel A request and word; a_ready = buffer A empty
//   b_valid/b_data      channel B request and word; b_ready = buffer B empty
//   out_valid/out_data  granted word held until out_ready
//   out_src             origin of out_data (1 = A, 0 = B)
//   out_ready           consumer accepts the current word
// ----------------------------------------------------------------------------
module mux2_rr_arbiter
   import mux2_rr_pkg::*;
#(
   parameter int DW = DW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          a_valid,
   input  logic [DW-1:0] a_data,
   output logic          a_ready,
   input  logic          b_valid,
   input  logic [DW-1:0] b_data,
   output logic          b_ready,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   output logic          out_src,
   input  logic          out_ready
);

   // buffer stage: vld_x_p0 is the buffer full flag
   logic          vld_a_p0, vld_b_p0;
   logic [DW-1:0] data_a_p0, data_b_p0;

   // output stage
   ostate_t       state_p1, state_nxt;
   logic [DW-1:0] data_p1;
   logic          src_p1;

   logic          pri;       // SEL_A: A wins a tie
   logic          load;
   logic          grant_a;
   logic          sel;
   logic [DW-1:0] mux_y;

   assign a_ready = !vld_a_p0;
   assign b_ready = !vld_b_p0;

   // Output may take a word when it is empty or its word leaves this edge.
   assign load    = ((state_p1 == O_EMPTY) || out_ready) && (vld_a_p0 || vld_b_p0);
   assign grant_a = vld_a_p0 && (!vld_b_p0 || (pri == SEL_A));
   assign sel     = grant_a ? SEL_A : SEL_B;

   mux2_rr_arbiter_mux #(.DW(DW)) u_mux (
      .input_x  (sel),
      .input_a  (data_a_p0),
      .input_b  (data_b_p0),
      .output_y (mux_y)
   );

   // ---- stage p0: channel buffers ----
   // Set and clear never collide: a buffer only accepts while empty and is
   // only granted while full.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_a_p0 <= 1'b0;
         vld_b_p0 <= 1'b0;
      end else begin
         if (a_valid && a_ready)
            vld_a_p0 <= 1'b1;
         else if (load && grant_a)
            vld_a_p0 <= 1'b0;
         if (b_valid && b_ready)
            vld_b_p0 <= 1'b1;
         else if (load && !grant_a)
            vld_b_p0 <= 1'b0;
      end
   end

   // Buffered words are qualified by the full flags, so they need no reset.
   always_ff @(posedge clk) begin
      if (a_valid && a_ready)
         data_a_p0 <= a_data;
      if (b_valid && b_ready)
         data_b_p0 <= b_data;
   end

   // ---- stage p1: output register and priority ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_p1 <= '0;
         src_p1  <= SEL_B;
         pri     <= SEL_A;
      end else if (load) begin
         data_p1 <= mux_y;
         src_p1  <= sel;
         pri     <= ~sel;   // next tie goes to the channel just passed over
      end
   end

   // Output FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_p1 <= O_EMPTY;
      else
         state_p1 <= state_nxt;
   end

   // Output FSM: next state
   always_comb begin
      state_nxt = state_p1;
      case (state_p1)
         O_EMPTY: if (load)               state_nxt = O_FULL;
         O_FULL:  if (out_ready && !load) state_nxt = O_EMPTY;
         default:                         state_nxt = O_EMPTY;
      endcase
   end

   // Output FSM: outputs
   always_comb begin
      out_valid = (state_p1 == O_FULL);
      out_data  = data_p1;
      out_src   = src_p1;
   end

endmodule : mux2_rr_arbiter

// File: tb/tb_mux2_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mux2_rr_arbiter
// Directed bench for mux2_rr_arbiter at DW=2, plus a per-channel scoreboard
// sweep over all 16 data pairs with random valid/out_ready.
// ----------------------------------------------------------------------------
module tb_mux2_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       a_valid, b_valid, out_ready;
   logic [1:0] a_data, b_data;
   logic       a_ready, b_ready, out_valid, out_src;
   logic [1:0] out_data;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mux2_rr_arbiter #(.DW(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a_valid   (a_valid),
      .a_data    (a_data),
      .a_ready   (a_ready),
      .b_valid   (b_valid),
      .b_data    (b_data),
      .b_ready   (b_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_ready (out_ready)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic v, input logic [1:0] d, input logic s);
      check({tag, "_valid"}, out_valid, v);
      if (v) begin
         check({tag, "_data"}, out_data, d);
         check({tag, "_src"},  out_src,  s);
      end
   endtask

   // Reset pulse between clock edges; caller is just past a rising edge.
   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   logic [1:0] qa[$];
   logic [1:0] qb[$];

   initial begin
      int a_idx, b_idx, got, cyc;
      logic fire_a, fire_b, take, os;
      logic [1:0] od, e;

      rst_n = 1'b0; a_valid = 0; b_valid = 0; a_data = 0; b_data = 0; out_ready = 0;
      tick(); tick();
      check("rst_a_ready", a_ready, 1);
      check("rst_b_ready", b_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_src", out_src, 0);
      #3 rst_n = 1'b1;
      tick();
      check("post_rst_a_ready", a_ready, 1);
      check("post_rst_b_ready", b_ready, 1);

      // single word on A
      a_valid = 1; a_data = 2'b10; out_ready = 1;
      tick();
      a_valid = 0;
      check("single_acc_a_ready", a_ready, 0);
      check_out("single_e0", 0, 0, 0);
      tick();
      check_out("single_e1", 1, 2, 1);
      check("single_a_ready_back", a_ready, 1);
      tick();
      check_out("single_e2", 0, 0, 0);

      // simultaneous pairs, A first after reset
      do_reset();
      a_valid = 1; b_valid = 1; a_data = 1; b_data = 3;
      tick();
      a_valid = 0; b_valid = 0;
      tick();
      check_out("sim1_first", 1, 1, 1);
      tick();
      check_out("sim1_second", 1, 3, 0);
      a_valid = 1; b_valid = 1; a_data = 2; b_data = 0;
      tick();
      a_valid = 0; b_valid = 0;
      tick();
      check_out("sim2_first", 1, 2, 1);
      tick();
      check_out("sim2_second", 1, 0, 0);
      tick();
      check_out("sim2_idle", 0, 0, 0);

      // backpressure with both buffers loaded
      out_ready = 0;
      a_valid = 1; b_valid = 1; a_data = 2; b_data = 1;
      tick();
      a_data = 3; b_valid = 0;
      tick();
      check_out("bp_first_load", 1, 2, 1);
      check("bp_a_ready_free", a_ready, 1);
      tick();
      a_valid = 1; a_data = 0; b_valid = 1; b_data = 0;
      for (int i = 0; i < 5; i++) begin
         check_out("bp_hold", 1, 2, 1);
         check("bp_a_ready", a_ready, 0);
         check("bp_b_ready", b_ready, 0);
         tick();
      end
      a_valid = 0; b_valid = 0; out_ready = 1;
      tick();
      check_out("bp_drain_b", 1, 1, 0);
      tick();
      check_out("bp_drain_a", 1, 3, 1);
      tick();
      check_out("bp_drained", 0, 0, 0);
      check("bp_end_a_ready", a_ready, 1);
      check("bp_end_b_ready", b_ready, 1);

      // all 16 data pairs, random handshakes, per-channel scoreboard
      a_idx = 0; b_idx = 0; got = 0; cyc = 0;
      while ((a_idx < 16 || b_idx < 16 || got < 32) && cyc < 2000) begin
         a_valid   = (a_idx < 16) && ($urandom_range(0, 1) == 1);
         b_valid   = (b_idx < 16) && ($urandom_range(0, 1) == 1);
         a_data    = a_idx[3:2];
         b_data    = b_idx[1:0];
         out_ready = ($urandom_range(0, 3) != 0);
         fire_a = a_valid && a_ready;
         fire_b = b_valid && b_ready;
         take   = out_valid && out_ready;
         od = out_data;
         os = out_src;
         tick();
         cyc++;
         if (fire_a) begin qa.push_back(a_data); a_idx++; end
         if (fire_b) begin qb.push_back(b_data); b_idx++; end
         if (take) begin
            got++;
            if (os) begin
               check("sb_a_pending", qa.size() > 0, 1);
               if (qa.size() > 0) begin e = qa.pop_front(); check("sb_a_word", od, e); end
            end else begin
               check("sb_b_pending", qb.size() > 0, 1);
               if (qb.size() > 0) begin e = qb.pop_front(); check("sb_b_word", od, e); end
            end
         end
      end
      check("sb_words_out", got, 32);
      check("sb_a_left", qa.size(), 0);
      check("sb_b_left", qb.size(), 0);
      a_valid = 0; b_valid = 0; out_ready = 1;
      tick(); tick();

      // asynchronous reset while a word is held
      out_ready = 0; a_valid = 1; a_data = 3;
      tick();
      a_valid = 0;
      tick();
      check_out("ar_loaded", 1, 3, 1);
      #3 rst_n = 1'b0;
      #1;
      check("ar_out_valid", out_valid, 0);
      check("ar_out_data", out_data, 0);
      check("ar_out_src", out_src, 0);
      check("ar_a_ready", a_ready, 1);
      #1 rst_n = 1'b1;
      a_valid = 1; b_valid = 1; a_data = 1; b_data = 2; out_ready = 1;
      tick();
      a_valid = 0; b_valid = 0;
      tick();
      check_out("ar_first", 1, 1, 1);
      tick();
      check_out("ar_second", 1, 2, 0);
      tick();
      check_out("ar_idle", 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_mux2_rr_arbiter
